// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: stop flags, per-stage stall vector encodings and the controller
// state type imported by the interface and the control module.
package pipe_ctrl_pkg;

    // Single-bit stop flags used when composing stall vectors.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vector: [0] bubble into ID/EX, [1] hold PC + IF/ID,
    // [2] hold ID/EX + EX/MEM.
    localparam logic [2:0] STALL_NONE   = {NO_STOP, NO_STOP, NO_STOP};
    localparam logic [2:0] STALL_BUBBLE = {NO_STOP, STOP,    STOP};
    localparam logic [2:0] STALL_HOLD   = {STOP,    STOP,    NO_STOP};
    localparam logic [2:0] STALL_ALL    = {STOP,    STOP,    STOP};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXWAIT   = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard/redirect requests and pipeline control outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; trap_req_i is a level held until trap_ack_o.
//
// Modports: master = core side (drives requests, sees controls),
//           slave  = pipe_ctrl side (sees requests, drives controls).
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic             stallreq_id_i;
    logic             stallreq_ex_i;
    logic             stallreq_mem_i;
    logic             ex_branch_flag_i;
    logic [31:0]      ex_branch_addr_i;
    logic             trap_req_i;
    logic [31:0]      trap_addr_i;
    logic [2:0]       stalled_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             trap_ack_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output ex_branch_flag_i, ex_branch_addr_i, trap_req_i, trap_addr_i,
        input  stalled_o, flush_o, new_pc_o, trap_ack_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  ex_branch_flag_i, ex_branch_addr_i, trap_req_i, trap_addr_i,
        output stalled_o, flush_o, new_pc_o, trap_ack_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stalls, branch redirects and trap entry.
// Latency: stall/flush are same-cycle combinational; trap ack one cycle after request on idle bus.
// Backpressure: mem-not-ready holds the trap in DRAIN (bounded by DRAIN_MAX) before redirect.
//
// Ports: clk, rst (async active-low), bus (pipe_ctrl_if.slave) carrying the
// ID/EX/MEM stall requests, EX branch, CSR trap handshake, and the stall
// vector, flush strobe, redirect PC and saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_MAX = 15,
    parameter int CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int DW = $clog2(DRAIN_MAX + 1);

    state_t           state, state_n;
    logic [DW-1:0]    drain_cnt, drain_n;
    logic [CNT_W-1:0] stall_cnt;

    logic [2:0]       stall_c;
    logic             flush_c;
    logic [31:0]      pc_c;
    logic             ack_c;

    always_comb begin
        stall_c = STALL_NONE;
        flush_c = 1'b0;
        pc_c    = 32'h0;
        ack_c   = 1'b0;
        state_n = state;
        drain_n = drain_cnt;
        case (state)
            ST_RUN: begin
                if (bus.trap_req_i) begin
                    // Stop fetch and let older instructions finish; the trap
                    // redirect (and flush of younger ones) happens in REDIRECT.
                    stall_c = STALL_BUBBLE;
                    if (bus.stallreq_mem_i) begin
                        state_n = ST_DRAIN;
                        drain_n = '0;
                    end else begin
                        state_n = ST_REDIRECT;
                    end
                end else if (bus.stallreq_mem_i) begin
                    // Holding ID/EX already covers the load-use case, so no bubble.
                    stall_c = STALL_HOLD;
                end else if (bus.ex_branch_flag_i) begin
                    flush_c = 1'b1;
                    pc_c    = bus.ex_branch_addr_i;
                end else if (bus.stallreq_ex_i) begin
                    stall_c = STALL_HOLD;
                    state_n = ST_EXWAIT;
                end else if (bus.stallreq_id_i) begin
                    stall_c = STALL_BUBBLE;
                end
            end
            ST_EXWAIT: begin
                // Branches and traps are deliberately ignored until back in RUN.
                if (bus.stallreq_ex_i) begin
                    stall_c = STALL_HOLD;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DRAIN: begin
                stall_c = STALL_ALL;
                drain_n = drain_cnt + DW'(1);
                // Timeout guarantees forward progress if the bus never frees.
                if (!bus.stallreq_mem_i || drain_cnt == DW'(DRAIN_MAX)) begin
                    state_n = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                flush_c = 1'b1;
                pc_c    = bus.trap_addr_i;
                ack_c   = 1'b1;
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
            if (stall_c != STALL_NONE && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stalled_o   = stall_c;
    assign bus.flush_o     = flush_c;
    assign bus.new_pc_o    = pc_c;
    assign bus.trap_ack_o  = ack_c;
    assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with directed scenarios and random traffic.
// Latency: outputs sampled at negedge, model advanced after posedge.
// Backpressure: trap_req held until the model predicts the ack.
module tb_pipe_ctrl;

    localparam int DRAIN_MAX = 15;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // Bench-side view of where the controller should be.
    localparam int M_RUN = 0, M_EXWAIT = 1, M_DRAIN = 2, M_REDIRECT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int m_mode  = M_RUN;
    int m_dwell = 0;   // DRAIN cycles already spent before the current one
    int m_cnt   = 0;
    bit last_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.stallreq_id_i    = 1'b0;
        bus.stallreq_ex_i    = 1'b0;
        bus.stallreq_mem_i   = 1'b0;
        bus.ex_branch_flag_i = 1'b0;
        bus.ex_branch_addr_i = 32'h0;
        bus.trap_req_i       = 1'b0;
        bus.trap_addr_i      = 32'h0;
    endtask

    // One clock: inputs are already driven; predict, compare at negedge, advance.
    task automatic step();
        logic [2:0]  es;
        logic        ef;
        logic [31:0] ep;
        logic        ea;
        int          nm;
        es = 3'b000; ef = 1'b0; ep = 32'h0; ea = 1'b0; nm = m_mode;
        @(negedge clk);
        if (m_mode == M_RUN) begin
            if (bus.trap_req_i) begin
                es = 3'b011;
                nm = bus.stallreq_mem_i ? M_DRAIN : M_REDIRECT;
            end else if (bus.stallreq_mem_i) es = 3'b110;
            else if (bus.ex_branch_flag_i) begin
                ef = 1'b1; ep = bus.ex_branch_addr_i;
            end else if (bus.stallreq_ex_i) begin
                es = 3'b110; nm = M_EXWAIT;
            end else if (bus.stallreq_id_i) es = 3'b011;
        end else if (m_mode == M_EXWAIT) begin
            if (bus.stallreq_ex_i) es = 3'b110;
            else nm = M_RUN;
        end else if (m_mode == M_DRAIN) begin
            es = 3'b111;
            if (!bus.stallreq_mem_i || m_dwell == DRAIN_MAX) nm = M_REDIRECT;
        end else begin
            ef = 1'b1; ep = bus.trap_addr_i; ea = 1'b1; nm = M_RUN;
        end
        check_eq("stalled", 32'(bus.stalled_o), 32'(es));
        check_eq("flush", 32'(bus.flush_o), 32'(ef));
        check_eq("new_pc", bus.new_pc_o, ep);
        check_eq("trap_ack", 32'(bus.trap_ack_o), 32'(ea));
        check_eq("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_cnt));
        @(posedge clk);
        #1;
        if (es != 3'b000 && m_cnt < CNT_MAX) m_cnt++;
        if (nm == M_DRAIN && m_mode != M_DRAIN) m_dwell = 0;
        else if (m_mode == M_DRAIN) m_dwell++;
        m_mode   = nm;
        last_ack = ea;
    endtask

    // Called at posedge+1; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        check_eq("rst_stalled", 32'(bus.stalled_o), 32'h0);
        check_eq("rst_flush", 32'(bus.flush_o), 32'h0);
        check_eq("rst_new_pc", bus.new_pc_o, 32'h0);
        check_eq("rst_trap_ack", 32'(bus.trap_ack_o), 32'h0);
        check_eq("rst_stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
        m_mode = M_RUN; m_dwell = 0; m_cnt = 0; last_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Holds the trap request until the model predicts an ack, bounded.
    task automatic run_trap(input logic [31:0] addr, input int mem_cycles);
        int k;
        bit got;
        got = 1'b0;
        bus.trap_req_i  = 1'b1;
        bus.trap_addr_i = addr;
        for (k = 0; k < 60 && !got; k++) begin
            bus.stallreq_mem_i = (k < mem_cycles);
            step();
            got = last_ack;
        end
        check_eq("trap_ack_seen", 32'(got), 32'h1);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        do_reset();
        step();

        // Load-use bubble for one cycle.
        bus.stallreq_id_i = 1'b1; step();
        idle_inputs(); step();

        // EX busy for 4 cycles, branch offered during the wait.
        bus.stallreq_ex_i = 1'b1; step();
        bus.ex_branch_flag_i = 1'b1; bus.ex_branch_addr_i = 32'h0000_0400;
        repeat (3) step();
        idle_inputs(); step();
        step();

        // Same-cycle branch redirect.
        bus.ex_branch_flag_i = 1'b1; bus.ex_branch_addr_i = 32'h0000_0100; step();
        idle_inputs(); step();

        // Mem and load-use together: hold, no bubble.
        bus.stallreq_mem_i = 1'b1; bus.stallreq_id_i = 1'b1; step();
        idle_inputs(); step();

        // Trap with idle bus, trap with branch at the same time.
        run_trap(32'h0000_0300, 0);
        bus.ex_branch_flag_i = 1'b1; bus.ex_branch_addr_i = 32'h0000_0500;
        run_trap(32'h0000_0600, 0);
        step();

        // Trap behind 3 cycles of mem busy, then stuck bus forcing the timeout.
        run_trap(32'h0000_0200, 3);
        step();
        run_trap(32'h0000_0700, 1000);
        step();

        // Reset in the middle of DRAIN: no ack afterwards.
        bus.trap_req_i = 1'b1; bus.trap_addr_i = 32'h0000_0800; bus.stallreq_mem_i = 1'b1;
        repeat (4) step();
        do_reset();
        repeat (3) step();

        // Reset in the middle of EXWAIT.
        bus.stallreq_ex_i = 1'b1;
        repeat (3) step();
        do_reset();
        step();

        // Random traffic long enough to saturate the counter several times.
        for (int i = 0; i < 1500; i++) begin
            bus.stallreq_id_i    = ($urandom_range(0, 3) == 0);
            bus.stallreq_ex_i    = ($urandom_range(0, 5) == 0);
            bus.stallreq_mem_i   = ($urandom_range(0, 4) == 0);
            bus.ex_branch_flag_i = ($urandom_range(0, 4) == 0);
            bus.ex_branch_addr_i = $urandom;
            if (!bus.trap_req_i && $urandom_range(0, 19) == 0) begin
                bus.trap_req_i  = 1'b1;
                bus.trap_addr_i = $urandom;
            end
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step();
                if (last_ack) bus.trap_req_i = 1'b0;
            end
        end

        // Saturated counter must hold through further stalls.
        idle_inputs();
        while (m_cnt < CNT_MAX) begin
            bus.stallreq_id_i = 1'b1; step();
        end
        repeat (3) step();
        check_eq("cnt_saturated", 32'(bus.stall_cnt_o), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
